acq_ring_sequencer: RTL and testbench



---
 rtl/acq_pkg.sv | 21 ++
 rtl/acq_req_hold.sv | 37 +++
 rtl/acq_ring_sequencer.sv | 127 ++++++++++++
 tb/tb_acq_ring_sequencer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/acq_pkg.sv
// Shared types and helpers for the acquisition ring sequencer.
package acq_pkg;

  localparam int IDX_W_DEF  = 22;
  localparam int ADDR_W_DEF = 23;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_ARMED,
    S_POST,
    S_READ,
    S_DRAIN
  } acq_state_t;

  // Each sample occupies two PSRAM words, so the word address is the index doubled.
  function automatic logic [32:0] idx_to_addr(input logic [31:0] idx);
    return {idx, 1'b0};
  endfunction

endpackage

// File: rtl/acq_req_hold.sv
// Single outstanding PSRAM request register, shared by the write and read paths.
module acq_req_hold #(
  parameter int ADDR_W = 23
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              load_rd,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              mem_ack,
  output logic              mem_wr_req,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] address_acq,
  output logic              pending
);

  logic is_rd;

  // A new load in the ack cycle replaces the completing request without a gap.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      pending     <= 1'b0;
      is_rd       <= 1'b0;
      address_acq <= '0;
    end else if (load) begin
      pending     <= 1'b1;
      is_rd       <= load_rd;
      address_acq <= load_addr;
    end else if (mem_ack) begin
      pending <= 1'b0;
    end
  end

  assign mem_wr_req = pending & ~is_rd;
  assign mem_rd_req = pending & is_rd;

endmodule

// File: rtl/acq_ring_sequencer.sv
// Circular-buffer write sequencing with pre/post-trigger windows and window readout.
module acq_ring_sequencer
  import acq_pkg::*;
#(
  parameter int IDX_W  = IDX_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [IDX_W-1:0]  pre_len,
  input  logic [IDX_W-1:0]  post_len,
  input  logic              sample_valid,
  input  logic              trigger,
  input  logic              mem_ack,
  output logic              mem_wr_req,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] address_acq,
  output logic [IDX_W-1:0]  i_pivot,
  output logic              busy,
  output logic              done,
  output logic              triggered,
  output logic              overrun
);

  acq_state_t state;
  logic [IDX_W-1:0] wr_idx, rd_idx, pre_cnt, post_cnt, pre_len_q, post_len_q;
  logic [IDX_W:0]   rd_cnt;
  logic             pending, req_free, active, accept, rd_load, load;
  logic [IDX_W-1:0] load_idx;
  logic [ADDR_W-1:0] load_addr;

  assign req_free = !pending || mem_ack;
  assign active   = (state == S_PRE) || (state == S_ARMED) ||
                    ((state == S_POST) && (post_cnt != post_len_q));
  assign accept   = active && sample_valid && req_free && !abort;

  // First read issues on READ entry; later reads chain off each ack until the last.
  assign rd_load  = (state == S_READ) && !abort &&
                    (!pending || (mem_ack && (rd_cnt != (IDX_W+1)'(1))));
  assign load      = accept || rd_load;
  assign load_idx  = accept ? wr_idx : (pending ? rd_idx + IDX_W'(1) : rd_idx);
  assign load_addr = ADDR_W'(idx_to_addr(32'(load_idx)));

  acq_req_hold #(.ADDR_W(ADDR_W)) u_hold (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .load       (load),
    .load_rd    (!accept),
    .load_addr  (load_addr),
    .mem_ack    (mem_ack),
    .mem_wr_req (mem_wr_req),
    .mem_rd_req (mem_rd_req),
    .address_acq(address_acq),
    .pending    (pending)
  );

  assign busy = (state != S_IDLE);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      wr_idx     <= '0;
      rd_idx     <= '0;
      pre_cnt    <= '0;
      post_cnt   <= '0;
      pre_len_q  <= '0;
      post_len_q <= '0;
      rd_cnt     <= '0;
      i_pivot    <= '0;
      done       <= 1'b0;
      triggered  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (active && sample_valid && !req_free) overrun <= 1'b1;
      if (accept) wr_idx <= wr_idx + IDX_W'(1);

      if (abort && (state != S_IDLE) && (state != S_DRAIN)) begin
        state <= (pending && !mem_ack) ? S_DRAIN : S_IDLE;
      end else begin
        case (state)
          S_IDLE: if (start) begin
            wr_idx     <= '0;
            pre_cnt    <= '0;
            triggered  <= 1'b0;
            overrun    <= 1'b0;
            pre_len_q  <= pre_len;
            post_len_q <= (post_len == '0) ? IDX_W'(1) : post_len;
            state      <= (pre_len == '0) ? S_ARMED : S_PRE;
          end
          S_PRE: if (accept) begin
            pre_cnt <= pre_cnt + IDX_W'(1);
            if (pre_cnt + IDX_W'(1) == pre_len_q) state <= S_ARMED;
          end
          // A one-sample post window still passes through POST to wait for its ack.
          S_ARMED: if (accept && trigger) begin
            i_pivot   <= wr_idx;
            triggered <= 1'b1;
            post_cnt  <= IDX_W'(1);
            state     <= S_POST;
          end
          S_POST: begin
            if (accept) post_cnt <= post_cnt + IDX_W'(1);
            if ((post_cnt == post_len_q) && req_free) begin
              rd_idx <= i_pivot - pre_len_q;
              rd_cnt <= {1'b0, pre_len_q} + {1'b0, post_len_q};
              state  <= S_READ;
            end
          end
          S_READ: if (pending && mem_ack) begin
            rd_idx <= rd_idx + IDX_W'(1);
            rd_cnt <= rd_cnt - (IDX_W+1)'(1);
            if (rd_cnt == (IDX_W+1)'(1)) begin
              done  <= 1'b1;
              state <= S_IDLE;
            end
          end
          S_DRAIN: if (mem_ack) state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_acq_ring_sequencer.sv
// Scoreboard bench: a sample-level ring model predicts every write, read and done event.
module tb_acq_ring_sequencer;

  localparam int IDX_W  = 4;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 16;

  logic sys_clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, abort = 1'b0, sample_valid = 1'b0, trigger = 1'b0, mem_ack = 1'b0;
  logic [IDX_W-1:0] pre_len = '0, post_len = '0;
  logic mem_wr_req, mem_rd_req, busy, done, triggered, overrun;
  logic [ADDR_W-1:0] address_acq;
  logic [IDX_W-1:0]  i_pivot;

  acq_ring_sequencer #(.IDX_W(IDX_W), .ADDR_W(ADDR_W)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .start(start), .abort(abort),
    .pre_len(pre_len), .post_len(post_len), .sample_valid(sample_valid),
    .trigger(trigger), .mem_ack(mem_ack), .mem_wr_req(mem_wr_req),
    .mem_rd_req(mem_rd_req), .address_acq(address_acq), .i_pivot(i_pivot),
    .busy(busy), .done(done), .triggered(triggered), .overrun(overrun)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {int kind; int addr;} txn_t;  // kind 0 write, 1 read, 2 done
  txn_t exp_q[$];
  int tests = 0, fails = 0;
  int ack_lat = 0, wait_cnt = 0;
  bit just_acked;
  int exp_pivot;
  bit exp_trig, exp_ovr, win_done;

  // Memory responder: acks each request ack_lat cycles after it first appears.
  always @(posedge sys_clk) begin
    #1;
    just_acked = mem_ack;
    mem_ack = 1'b0;
    if (!rst_n) wait_cnt = 0;
    else if (mem_wr_req || mem_rd_req) begin
      if (just_acked) wait_cnt = 0;
      if (wait_cnt >= ack_lat) begin mem_ack = 1'b1; wait_cnt = 0; end
      else wait_cnt++;
    end else wait_cnt = 0;
  end

  task automatic popCompare(input int kind, input int addr);
    txn_t e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("[TB] FAIL unexpected_event: got kind=%0d addr=%0d, want nothing", kind, addr);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.addr != addr) begin
        fails++;
        $display("[TB] FAIL txn_order: got kind=%0d addr=%0d, want kind=%0d addr=%0d",
                 kind, addr, e.kind, e.addr);
      end
    end
  endtask

  always @(negedge sys_clk) begin
    if (rst_n) begin
      if (mem_wr_req && mem_rd_req) begin
        tests++; fails++;
        $display("[TB] FAIL req_exclusive: got wr=1 rd=1, want at most one");
      end
      if ((mem_wr_req || mem_rd_req) && mem_ack) popCompare(mem_rd_req ? 1 : 0, int'(address_acq));
      if (done) popCompare(2, 0);
    end
  end

  task automatic tick();
    @(posedge sys_clk); #1;
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Directed when trig_mask != 0 (bit k = trigger on attempt k); otherwise random gaps/triggers.
  task automatic applyStimulus(input int pre, input int post, input int lat,
                               input int trig_mask, input int drop_mask, input int max_att);
    int post_eff, wr_idx, pre_cnt, post_cnt, since, gap, ri;
    bit armed, in_post, trg;
    post_eff = (post == 0) ? 1 : post;
    wr_idx = 0; pre_cnt = 0; post_cnt = 0; since = 1000;
    armed = (pre == 0); in_post = 0;
    exp_trig = 0; exp_ovr = 0; win_done = 0;
    ack_lat = lat;
    pre_len = IDX_W'(pre); post_len = IDX_W'(post);
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 1; k <= max_att && !win_done; k++) begin
      if (trig_mask != 0) begin
        gap = drop_mask[k] ? 1 : lat + 1;
        trg = trig_mask[k];
      end else begin
        gap = int'($urandom_range(1, lat + 2));
        trg = ($urandom_range(0, 3) == 0);
      end
      repeat (gap - 1) tick();
      sample_valid = 1'b1; trigger = trg;
      tick();
      sample_valid = 1'b0; trigger = 1'b0;
      since += gap;
      if (since >= lat + 1) begin
        since = 0;
        exp_q.push_back('{0, (wr_idx % DEPTH) * 2});
        if (in_post) post_cnt++;
        else if (armed) begin
          if (trg) begin exp_pivot = wr_idx % DEPTH; exp_trig = 1; in_post = 1; post_cnt = 1; end
        end else begin
          pre_cnt++;
          if (pre_cnt == pre) armed = 1;
        end
        wr_idx++;
        if (in_post && post_cnt == post_eff) win_done = 1;
      end else exp_ovr = 1;
    end
    if (win_done) begin
      ri = ((exp_pivot - pre) % DEPTH + DEPTH) % DEPTH;
      for (int j = 0; j < pre + post_eff; j++) exp_q.push_back('{1, ((ri + j) % DEPTH) * 2});
      exp_q.push_back('{2, 0});
    end
  endtask

  task automatic waitDone(input string name);
    int n = 0;
    checkOutput({name, "_window"}, int'(win_done), 1);
    while (exp_q.size() != 0 && n < 3000) begin tick(); n++; end
    checkOutput({name, "_drain_left"}, exp_q.size(), 0);
    exp_q.delete();
    tick();
    @(negedge sys_clk);
    checkOutput({name, "_busy"}, int'(busy), 0);
    checkOutput({name, "_triggered"}, int'(triggered), int'(exp_trig));
    checkOutput({name, "_pivot"}, int'(i_pivot), exp_pivot);
    checkOutput({name, "_overrun"}, int'(overrun), int'(exp_ovr));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n, pre, post, lat;
    repeat (2) @(negedge sys_clk);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_wr_req", int'(mem_wr_req), 0);
    checkOutput("rst_rd_req", int'(mem_rd_req), 0);
    checkOutput("rst_addr", int'(address_acq), 0);
    checkOutput("rst_pivot", int'(i_pivot), 0);
    checkOutput("rst_flags", int'({done, triggered, overrun}), 0);
    tick(); rst_n = 1'b1; tick();

    applyStimulus(4, 3, 1, 1 << 7, 0, 30);
    waitDone("t1");
    checkOutput("t1_pivot_const", int'(i_pivot), 6);

    applyStimulus(4, 2, 0, (1 << 1) | (1 << 2) | (1 << 3) | (1 << 5), 0, 30);
    waitDone("t2");
    checkOutput("t2_pivot_const", int'(i_pivot), 4);

    applyStimulus(2, 2, 3, 1 << 4, 1 << 3, 30);
    waitDone("t3");
    checkOutput("t3_overrun_const", int'(overrun), 1);

    applyStimulus(6, 3, 0, 1 << 19, 0, 30);
    waitDone("t4");
    checkOutput("t4_pivot_const", int'(i_pivot), 2);

    // Abort with a write in flight: request must be held, then IDLE with no done.
    applyStimulus(2, 5, 4, 1 << 3, 0, 4);
    abort = 1'b1; tick(); abort = 1'b0;
    @(negedge sys_clk);
    checkOutput("t5_wr_held", int'(mem_wr_req), 1);
    checkOutput("t5_busy_drain", int'(busy), 1);
    n = 0;
    while (busy && n < 50) begin tick(); n++; end
    repeat (3) tick();
    @(negedge sys_clk);
    checkOutput("t5_busy", int'(busy), 0);
    checkOutput("t5_left", exp_q.size(), 0);
    checkOutput("t5_triggered", int'(triggered), 1);
    exp_q.delete();

    for (int r = 0; r < 6; r++) begin
      pre = int'($urandom_range(0, 8));
      post = int'($urandom_range(0, 7));
      lat = int'($urandom_range(0, 3));
      applyStimulus(pre, post, lat, 0, 0, 400);
      waitDone($sformatf("rnd%0d", r));
    end

    // Asynchronous reset mid-acquisition abandons everything.
    applyStimulus(3, 3, 2, 0, 0, 2);
    rst_n = 1'b0; exp_q.delete();
    #2;
    checkOutput("mid_rst_busy", int'(busy), 0);
    checkOutput("mid_rst_req", int'({mem_wr_req, mem_rd_req}), 0);
    tick(); rst_n = 1'b1; tick();
    applyStimulus(0, 1, 0, 0, 0, 400);
    waitDone("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
